warp_scheduler: RTL and testbench
=================================

# warp_scheduler

Frame-level sequencer for the image-warping pipeline. On a start command it walks every destination pixel of a `hres` × `vres` frame in raster order and presents each coordinate to the pixel-address stage through a ready/next handshake. It bounds in-flight work with a pending counter fed by write acknowledgements from the memory back end. It reports `busy`, a `done` pulse, abort status and a completed-frame count to the control interface.

## Interface
Parameters:
- `MAX_PENDING`, default 16: maximum issued-but-unacknowledged pixels; range 1..(2^PENDW)-1.
- `PENDW`, default 5: width of the pending counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle command that begins a frame; ignored while `busy`.
- `abort`  in  1  one-cycle command that stops issuing; ignored while idle.
- `hres`  in  11  frame width in pixels; sampled on accepted `start`.
- `vres`  in  11  frame height in pixels; sampled on accepted `start`.
- `td_x`  out  11  destination x coordinate; valid while `t_ready`.
- `td_y`  out  11  destination y coordinate; valid while `t_ready`.
- `t_ready`  out  1  coordinate valid.
- `t_next`  in  1  downstream accepts; a transfer occurs on `t_ready & t_next`.
- `wr_ack`  in  1  one pulse per pixel completed by the write back end.
- `pending`  out  PENDW  in-flight pixel count.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle end-of-frame pulse; also used for aborted and empty frames.
- `aborted`  out  1  last frame ended by abort; held until next accepted `start`.
- `ack_err`  out  1  sticky: `wr_ack` arrived while `pending == 0`; cleared on accepted `start`.
- `frame_count`  out  16  frames completed normally; wraps at 65535 → 0.

## Operation
- Reset values: all outputs 0; state IDLE; internal `x`, `y`, `hres_r` and `vres_r` are 0.
- State machine:
  - **IDLE**: `start` with latched sizes both nonzero → SCAN, with x = y = 0, `busy` = 1, `aborted` = 0 and `ack_err` = 0.
  - **IDLE**, empty frame: `start` with `hres == 0` or `vres == 0` → stay IDLE, pulse `done` the next cycle, leave `frame_count` unchanged.
  - **SCAN**: `t_ready` = (`pending` < `MAX_PENDING`).
    - On each transfer, x increments.
    - When x == `hres_r` − 1, x wraps to 0 and y increments.
    - A transfer at (`hres_r` − 1, `vres_r` − 1) → DRAIN.
  - **DRAIN**: `t_ready` = 0. When the next-state pending value is 0 → IDLE, `done` = 1, `busy` = 0, and `frame_count` increments unless the frame was aborted.
  - **Abort in SCAN**: → DRAIN, `aborted` = 1; a transfer in the same cycle still counts.
  - **Abort in DRAIN**: sets `aborted` = 1 only.
- Pending counter:
  - next value = `pending` + transfer − `wr_ack`; a simultaneous transfer and ack leave it unchanged.
  - `wr_ack` at 0 is dropped, `pending` stays 0, and `ack_err` is set.
- `td_x` and `td_y` are driven directly from the registered x and y and stay stable while `t_ready` is high and `t_next` is low.
- `start` while `busy`: ignored, with no effect on state or sizes.
- `start` and `abort` in the same cycle from IDLE: the start is accepted and the abort is ignored.

## Timing
- `start` at cycle N → `busy` = 1, `t_ready` = 1, coordinates (0,0) at N+1.
- A transfer at cycle N → the next coordinate is valid at N+1. Back-to-back transfers reach 1 pixel/cycle while below `MAX_PENDING`.
- `pending` reaches `MAX_PENDING` at cycle N → `t_ready` = 0 at N. A `wr_ack` at N restores `t_ready` at N+1.
- The last transfer at N → DRAIN and `t_ready` = 0 at N+1.
- The ack that empties `pending` at cycle M → `done` = 1 and `busy` = 0 at M+1; `done` falls at M+2.
  - If `pending` is already 0 on entry to DRAIN, `done` asserts one cycle after entry.
- Abort at N → `t_ready` = 0 at N+1.
- `rst_n` low at any time immediately forces reset values. Acks arriving after reset are ignored and set no flags until the next `start`.

## Structure
- Shared warp package holds:
  - state encoding (IDLE/SCAN/DRAIN);
  - the 11-bit coordinate width constant shared with pixel addressing and the mesh stages;
  - the 30-bit memory address width.
- One natural sub-module: `warp_raster_counter`, the x/y raster walker with an advance input, size inputs, a clear, and a last-pixel flag.
- The pending counter and FSM live in the top module.

## Test plan
- 4×2 frame, `t_next` = 1, ack each pixel 3 cycles after transfer → coordinates (0,0)…(3,0),(0,1)…(3,1); `done` 3 cycles after the 8th transfer; `frame_count` = 1.
- 4×4 frame, `MAX_PENDING` = 2, no acks → `t_ready` drops after 2 transfers; one ack → exactly one more transfer.
- 16×16 frame, abort after 5 transfers with 5 pending → no further transfers; `done` after 5 acks; `aborted` = 1; `frame_count` unchanged.
- `start` with `hres` = 0 → `done` at N+1; `busy` never rises; no transfers.
- `start` while busy, plus `wr_ack` while idle → sizes unchanged; `ack_err` = 1; `pending` stays 0.
- `rst_n` low mid-SCAN with pending = 3 → all outputs 0 immediately; a following `start` of 2×1 completes normally.

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
// Shared warp-pipeline types and widths: scheduler state encoding plus the
// coordinate and memory address widths used across the warp stages.
package warp_scheduler_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned ADDR_W  = 30;
  localparam int unsigned FCNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/warp_raster_counter.sv
// Raster-order x/y walker: advances one pixel per i_advance, wraps x at the
// end of each line and flags the final pixel of the frame.
module warp_raster_counter
  import warp_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_advance,
  input  logic [COORD_W-1:0] i_hres,
  input  logic [COORD_W-1:0] i_vres,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last_c
);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               w_eol;

  assign w_eol    = (r_x == i_hres - COORD_W'(1));
  assign o_last_c = w_eol && (r_y == i_vres - COORD_W'(1));
  assign o_x      = r_x;
  assign o_y      = r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Frame sequencer: walks a hres x vres frame in raster order behind a
// ready/next handshake, throttled by an in-flight pending counter.
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 16,
  parameter int unsigned PENDW       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] hres,
  input  logic [COORD_W-1:0] vres,
  output logic [COORD_W-1:0] td_x,
  output logic [COORD_W-1:0] td_y,
  output logic               t_ready,
  input  logic               t_next,
  input  logic               wr_ack,
  output logic [PENDW-1:0]   pending,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               ack_err,
  output logic [FCNT_W-1:0]  frame_count
);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic [COORD_W-1:0] r_hres;
  logic [COORD_W-1:0] r_vres;
  logic [PENDW-1:0]   r_pending;
  logic [PENDW-1:0]   w_pend_nxt;
  logic               r_t_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_aborted;
  logic               r_ack_err;
  logic               r_armed;
  logic [FCNT_W-1:0]  r_fcnt;
  logic               w_done_nxt;
  logic               w_fcnt_inc;
  logic               w_xfer;
  logic               w_start_ok;
  logic               w_size_ok;
  logic               w_ack_ok;
  logic               w_ack_bad;
  logic               w_last_c;

  assign w_xfer     = r_t_ready && t_next;
  assign w_start_ok = start && (r_state == ST_IDLE);
  assign w_size_ok  = (hres != '0) && (vres != '0);
  assign w_ack_ok   = wr_ack && (r_pending != '0);
  // Acks with nothing in flight are dropped; only flagged once a frame has been started.
  assign w_ack_bad  = wr_ack && (r_pending == '0) && r_armed;

  warp_raster_counter u_raster (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_start_ok),
    .i_advance (w_xfer),
    .i_hres    (r_hres),
    .i_vres    (r_vres),
    .o_x       (td_x),
    .o_y       (td_y),
    .o_last_c  (w_last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_fcnt_inc  = 1'b0;
    case ({w_xfer, w_ack_ok})
      2'b10:   w_pend_nxt = r_pending + PENDW'(1);
      2'b01:   w_pend_nxt = r_pending - PENDW'(1);
      default: w_pend_nxt = r_pending;
    endcase
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          if (w_size_ok) w_state_nxt = ST_SCAN;
          else           w_done_nxt  = 1'b1;
        end
      end
      ST_SCAN: begin
        if ((w_xfer && w_last_c) || abort) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pend_nxt == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_fcnt_inc  = !(r_aborted || abort);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status outputs are registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hres    <= '0;
      r_vres    <= '0;
      r_pending <= '0;
      r_t_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_ack_err <= 1'b0;
      r_armed   <= 1'b0;
      r_fcnt    <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_t_ready <= (w_state_nxt == ST_SCAN) && (w_pend_nxt < PENDW'(MAX_PENDING));
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      if (w_fcnt_inc) r_fcnt <= r_fcnt + FCNT_W'(1);
      if (w_start_ok) begin
        r_hres    <= hres;
        r_vres    <= vres;
        r_aborted <= 1'b0;
        r_ack_err <= 1'b0;
        r_armed   <= 1'b1;
      end else begin
        if (abort && (r_state != ST_IDLE)) r_aborted <= 1'b1;
        if (w_ack_bad)                     r_ack_err <= 1'b1;
      end
    end
  end

  assign t_ready     = r_t_ready;
  assign pending     = r_pending;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign ack_err     = r_ack_err;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: vector table, directed corner
// sequences and a randomized run against a pixel-index reference model.
module tb_warp_scheduler;

  localparam int MAXP = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, t_next, wr_ack;
  logic [10:0] hres, vres;
  logic [10:0] td_x, td_y;
  logic        t_ready, busy, done, aborted, ack_err;
  logic [4:0]  pending;
  logic [15:0] frame_count;

  logic        start_b, abort_b, t_next_b, wr_ack_b;
  logic [10:0] td_x_b, td_y_b;
  logic        t_ready_b, busy_b, done_b, aborted_b, ack_err_b;
  logic [4:0]  pending_b;
  logic [15:0] frame_count_b;

  always #5 clk = ~clk;

  warp_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hres(hres), .vres(vres),
    .td_x(td_x), .td_y(td_y), .t_ready(t_ready), .t_next(t_next), .wr_ack(wr_ack),
    .pending(pending), .busy(busy), .done(done), .aborted(aborted), .ack_err(ack_err),
    .frame_count(frame_count)
  );

  warp_scheduler #(.MAX_PENDING(2), .PENDW(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .hres(hres), .vres(vres),
    .td_x(td_x_b), .td_y(td_y_b), .t_ready(t_ready_b), .t_next(t_next_b), .wr_ack(wr_ack_b),
    .pending(pending_b), .busy(busy_b), .done(done_b), .aborted(aborted_b), .ack_err(ack_err_b),
    .frame_count(frame_count_b)
  );

  typedef struct {
    int st, ab, h, v, tn, ack;
    int rdy, x, y, pend, busy, done, abd, err, fc;
  } vec_t;

  vec_t tbl[16];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cnt, extra, xfers, last_xfer, done_cyc;
  bit   ack_q[64];

  // Reference model: frame progress is a linear pixel index, not x/y counters.
  bit m_run, m_iss, m_done, m_ab, m_err, m_armed;
  int m_pend, m_cnt, m_tot, m_h, m_v, m_fc;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int pack(input int rdy, pend, bsy, dn, abd, err, fc);
    return (rdy << 25) | (pend << 20) | (bsy << 19) | (dn << 18) | (abd << 17) | (err << 16) | fc;
  endfunction

  function automatic int act_vec();
    return int'({t_ready, pending, busy, done, aborted, ack_err, frame_count});
  endfunction

  function automatic bit m_rdy();
    return m_run && m_iss && (m_pend < MAXP);
  endfunction

  task automatic model_reset();
    m_run = 0; m_iss = 0; m_done = 0; m_ab = 0; m_err = 0; m_armed = 0;
    m_pend = 0; m_cnt = 0; m_tot = 0; m_h = 0; m_v = 0; m_fc = 0;
  endtask

  task automatic model_step(input bit st, ab, input int h, v, input bit tn, ack);
    bit xf, ack_ok, ack_bad;
    int np;
    xf      = m_rdy() && tn;
    ack_ok  = ack && (m_pend > 0);
    ack_bad = ack && (m_pend == 0) && m_armed;
    np      = m_pend + int'(xf) - int'(ack_ok);
    m_done  = 0;
    if (!m_run) begin
      if (st) begin
        m_armed = 1; m_ab = 0; m_err = 0; m_h = h; m_v = v;
        if (h != 0 && v != 0) begin
          m_run = 1; m_iss = 1; m_cnt = 0; m_tot = h * v;
        end else m_done = 1;
      end else if (ack_bad) m_err = 1;
    end else begin
      if (m_iss) begin
        if (xf) m_cnt++;
        if (ab || m_cnt == m_tot) m_iss = 0;
      end else if (np == 0) begin
        m_run = 0; m_done = 1;
        if (!(m_ab || ab)) m_fc = (m_fc + 1) % 65536;
      end
      if (ab) m_ab = 1;
      if (ack_bad) m_err = 1;
    end
    m_pend = np;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; t_next = 0; wr_ack = 0;
    start_b = 0; abort_b = 0; t_next_b = 0; wr_ack_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    hres = '0; vres = '0;
    // st ab h v tn ack | rdy x y pend busy done abd err fc
    tbl[0]  = '{0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0};
    tbl[1]  = '{1,0,3,1,0,0, 1,0,0,0,1,0,0,0,0};
    tbl[2]  = '{0,0,3,1,1,0, 1,1,0,1,1,0,0,0,0};
    tbl[3]  = '{1,0,5,5,0,0, 1,1,0,1,1,0,0,0,0};
    tbl[4]  = '{0,0,0,0,1,1, 1,2,0,1,1,0,0,0,0};
    tbl[5]  = '{0,0,0,0,1,0, 0,0,0,2,1,0,0,0,0};
    tbl[6]  = '{0,0,0,0,0,1, 0,0,0,1,1,0,0,0,0};
    tbl[7]  = '{0,0,0,0,0,1, 0,0,0,0,0,1,0,0,1};
    tbl[8]  = '{0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1};
    tbl[9]  = '{0,0,0,0,0,1, 0,0,0,0,0,0,0,1,1};
    tbl[10] = '{1,0,0,2,0,0, 0,0,0,0,0,1,0,0,1};
    tbl[11] = '{0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1};
    tbl[12] = '{1,1,1,1,0,0, 1,0,0,0,1,0,0,0,1};
    tbl[13] = '{0,1,0,0,1,0, 0,0,0,1,1,0,1,0,1};
    tbl[14] = '{0,0,0,0,0,1, 0,0,0,0,0,1,1,0,1};
    tbl[15] = '{0,0,0,0,0,0, 0,0,0,0,0,0,1,0,1};

    do_reset();
    chk("reset_vec", act_vec(), 0);
    chk("reset_xy", int'({td_x, td_y}), 0);

    for (int i = 0; i < 16; i++) begin
      start = 1'(tbl[i].st); abort = 1'(tbl[i].ab);
      hres = 11'(tbl[i].h); vres = 11'(tbl[i].v);
      t_next = 1'(tbl[i].tn); wr_ack = 1'(tbl[i].ack);
      tick();
      chk($sformatf("vec%0d", i), act_vec(),
          pack(tbl[i].rdy, tbl[i].pend, tbl[i].busy, tbl[i].done, tbl[i].abd, tbl[i].err, tbl[i].fc));
      if (tbl[i].rdy != 0) chk($sformatf("vec%0d_xy", i), int'({td_x, td_y}), (tbl[i].x << 11) | tbl[i].y);
    end
    idle_inputs();

    // 4x2 frame, acks three cycles after each transfer
    do_reset();
    hres = 11'd4; vres = 11'd2; start = 1; tick(); start = 0;
    for (int i = 0; i < 64; i++) ack_q[i] = 0;
    xfers = 0; last_xfer = -1; done_cyc = -1;
    t_next = 1;
    for (int c = 0; c < 40; c++) begin
      wr_ack = ack_q[c];
      if (t_ready && t_next) begin
        chk($sformatf("a_xy%0d", xfers), int'({td_x, td_y}), ((xfers % 4) << 11) | (xfers / 4));
        ack_q[c + 3] = 1;
        last_xfer = c;
        xfers++;
      end
      tick();
      if (done && done_cyc < 0) done_cyc = c;
    end
    idle_inputs();
    chk("a_xfers", xfers, 8);
    chk("a_done_cycle", done_cyc, last_xfer + 3);
    chk("a_frame_count", int'(frame_count), 1);
    chk("a_busy", int'(busy), 0);

    // MAX_PENDING = 2 instance: throttle and single-ack release
    hres = 11'd4; vres = 11'd4; start_b = 1; tick(); start_b = 0;
    t_next_b = 1; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (t_ready_b) cnt++;
      tick();
    end
    chk("b_xfers_full", cnt, 2);
    chk("b_pending", int'(pending_b), 2);
    chk("b_ready_low", int'(t_ready_b), 0);
    wr_ack_b = 1; tick(); wr_ack_b = 0;
    for (int c = 0; c < 8; c++) begin
      if (t_ready_b) cnt++;
      tick();
    end
    chk("b_xfers_after_ack", cnt, 3);
    t_next_b = 0;

    // 16x16 frame aborted with 5 in flight
    hres = 11'd16; vres = 11'd16; start = 1; tick(); start = 0;
    t_next = 1; cnt = 0;
    for (int c = 0; c < 20 && cnt < 5; c++) begin
      if (t_ready) cnt++;
      tick();
    end
    t_next = 0; abort = 1; tick(); abort = 0;
    chk("c_pending", int'(pending), 5);
    chk("c_aborted", int'(aborted), 1);
    t_next = 1; extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (t_ready) extra++;
      tick();
    end
    t_next = 0;
    chk("c_no_more_xfers", extra, 0);
    for (int k = 0; k < 5; k++) begin
      wr_ack = 1; tick(); wr_ack = 0;
      chk($sformatf("c_done_ack%0d", k), int'(done), (k == 4) ? 1 : 0);
    end
    chk("c_end_vec", act_vec(), pack(0, 0, 0, 1, 1, 0, 1));

    // empty frame
    hres = 11'd0; vres = 11'd5; start = 1; tick(); start = 0;
    chk("d_done", act_vec(), pack(0, 0, 0, 1, 0, 0, 1));
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      extra += int'(busy) + int'(t_ready) + int'(done);
    end
    chk("d_quiet", extra, 0);

    // reset in the middle of a scan with 3 pending
    hres = 11'd8; vres = 11'd8; start = 1; tick(); start = 0;
    t_next = 1; cnt = 0;
    for (int c = 0; c < 10 && cnt < 3; c++) begin
      if (t_ready) cnt++;
      tick();
    end
    t_next = 0;
    chk("f_pending", int'(pending), 3);
    #2 rst_n = 0;
    #1;
    chk("f_async_vec", act_vec(), 0);
    chk("f_async_xy", int'({td_x, td_y}), 0);
    @(posedge clk); #1; rst_n = 1;
    wr_ack = 1; tick(); wr_ack = 0;
    chk("f_ack_ignored", act_vec(), 0);
    hres = 11'd2; vres = 11'd1; start = 1; tick(); start = 0;
    t_next = 1; tick(); tick(); t_next = 0;
    chk("f_pending2", act_vec(), pack(0, 2, 1, 0, 0, 0, 0));
    wr_ack = 1; tick(); tick(); wr_ack = 0;
    chk("f_done", act_vec(), pack(0, 0, 0, 1, 0, 0, 1));

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom % 20) == 0;
      abort  = ($urandom % 60) == 0;
      hres   = 11'($urandom_range(0, 6));
      vres   = 11'($urandom_range(0, 4));
      t_next = ($urandom % 10) < 8;
      wr_ack = (m_pend > 0) ? (($urandom % 10) < 3) : (($urandom % 100) == 0);
      tick();
      model_step(start, abort, int'(hres), int'(vres), t_next, wr_ack);
      chk($sformatf("rnd%0d", c), act_vec(),
          pack(int'(m_rdy()), m_pend, int'(m_run), int'(m_done), int'(m_ab), int'(m_err), m_fc));
      if (m_rdy()) chk($sformatf("rnd%0d_xy", c), int'({td_x, td_y}), ((m_cnt % m_h) << 11) | (m_cnt / m_h));
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
